// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_unit
// Purpose  : Walks a register-file read port from FIRST_REG to LAST_REG and
//            streams each (index, value) pair out over a valid/ready channel.
//            Each beat takes a READ cycle (capture) followed by a SEND cycle
//            (held until accepted), so a free-running consumer sees one beat
//            every two cycles.
// Ports    : clk        - clock, all state changes on the rising edge
//            rstn       - asynchronous active-low reset
//            start      - one-cycle dump request, honoured only when idle
//            abort      - terminates an active dump (ignored when idle)
//            rd_addr    - register-file read address (tracks current index)
//            rd_data    - combinational read data for rd_addr
//            out_valid  - out_idx/out_data hold a beat
//            out_ready  - consumer accepts the beat when valid && ready
//            out_idx    - register index of the current beat
//            out_data   - captured register value
//            busy       - high while a dump is in progress
//            done       - one-cycle pulse after the final beat or an abort
// Params   : FIRST_REG, LAST_REG - inclusive index range, 0 <= FIRST <= LAST <= 31
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_unit #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] c_first_reg = 5'(FIRST_REG);
    localparam logic [4:0] c_last_reg  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic        r_out_valid;
    logic [4:0]  r_out_idx;
    logic [31:0] r_out_data;
    logic        r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_idx       <= c_first_reg;
            r_out_valid <= 1'b0;
            r_out_idx   <= 5'd0;
            r_out_data  <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort has no meaning here, so start always wins
                    if (start) begin
                        r_idx   <= c_first_reg;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        // Capture the value present on the port at this edge;
                        // a write landing on the same edge is not observed.
                        r_out_data  <= rd_data;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // abort takes priority over a simultaneous acceptance
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_idx == c_last_reg) begin
                            // index stays at LAST_REG: no wrap past the range
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // The read address simply follows the index register: it equals idx in
    // READ and holds the last index everywhere else.
    assign rd_addr   = r_idx;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_unit
// Purpose  : Self-checking bench for reg_dump_unit. A synchronous register
//            file feeds two instances (full range and 5..7). Expected beats
//            are built from a snapshot of the register file at dump start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start     [2];
    logic        abort     [2];
    logic        out_ready [2];
    logic [4:0]  rd_addr   [2];
    logic [31:0] rd_data   [2];
    logic        out_valid [2];
    logic [4:0]  out_idx   [2];
    logic [31:0] out_data  [2];
    logic        busy      [2];
    logic        done      [2];

    logic [31:0] regs [32];
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Synchronous write port: a write and a dump capture on the same edge
    // both see the pre-write contents.
    always @(posedge clk) if (we) regs[waddr] <= wdata;

    assign rd_data[0] = regs[rd_addr[0]];
    assign rd_data[1] = regs[rd_addr[1]];

    reg_dump_unit u_dut0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .abort(abort[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_idx(out_idx[0]), .out_data(out_data[0]),
        .busy(busy[0]), .done(done[0])
    );

    reg_dump_unit #(.FIRST_REG(5), .LAST_REG(7)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start[1]), .abort(abort[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_idx(out_idx[1]), .out_data(out_data[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int u = 0; u < 2; u++) begin
            check({tag, "_valid"}, 32'(out_valid[u]), 32'd0);
            check({tag, "_idx"},   32'(out_idx[u]),   32'd0);
            check({tag, "_data"},  out_data[u],       32'd0);
            check({tag, "_busy"},  32'(busy[u]),      32'd0);
            check({tag, "_done"},  32'(done[u]),      32'd0);
            check({tag, "_rdaddr"}, 32'(rd_addr[u]),  (u == 0) ? 32'd0 : 32'd5);
        end
    endtask

    // mode 0: x2=0x24, rest 0; mode 1: random contents
    task automatic fill(input int mode);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we    = 1'b1;
            waddr = 5'(i);
            wdata = (mode == 0) ? ((i == 2) ? 32'h24 : 32'd0) : $urandom;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    // Runs one dump on instance u and checks every accepted beat against the
    // expected list. abort_idx >= 0 aborts during the SEND of that index.
    task automatic run_dump(input int u, input int first, input int last,
                            input bit rand_rdy, input int abort_idx,
                            input bit restart, input bit wr3, input logic [31:0] wr3_val);
        logic [4:0]  exp_idx[$];
        logic [31:0] exp_data[$];
        int          beats = 0, ndone = 0, done_n = -1, abort_n = -1, first_v = -1, n = 0;
        bit          prev_stall = 0, wrote = 0;
        logic [4:0]  p_idx = '0;
        logic [31:0] p_data = '0;
        int          exp_beats;

        for (int i = first; i <= last; i++) begin
            exp_idx.push_back(5'(i));
            exp_data.push_back(regs[i]);
        end
        exp_beats = (abort_idx >= 0) ? (abort_idx - first) : (last - first + 1);

        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);           // start sampled at the edge just passed (n = 0)
        start[u] = 1'b0;
        forever begin
            abort[u]     = 1'b0;
            we           = 1'b0;
            start[u]     = restart && (n == 3 || n == 20);
            out_ready[u] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

            if (done[u]) begin
                ndone++;
                done_n = n;
            end
            if (out_valid[u] && first_v < 0) first_v = n;
            if (prev_stall) begin
                check("stall_idx_stable", 32'(out_idx[u]), 32'(p_idx));
                check("stall_data_stable", out_data[u], p_data);
            end
            if (abort_n >= 0 && n == abort_n + 1) begin
                check("abort_valid_clr", 32'(out_valid[u]), 32'd0);
                check("abort_busy_clr", 32'(busy[u]), 32'd0);
            end
            if (out_valid[u] && abort_n < 0) begin
                if (abort_idx >= 0 && int'(out_idx[u]) == abort_idx) begin
                    abort[u]     = 1'b1;
                    out_ready[u] = 1'b1;
                    abort_n      = n;
                end else if (out_ready[u]) begin
                    if (exp_idx.size() == 0) begin
                        check("extra_beat", 32'(out_idx[u]), 32'hFFFF_FFFF);
                    end else begin
                        check("beat_idx", 32'(out_idx[u]), 32'(exp_idx.pop_front()));
                        check("beat_data", out_data[u], exp_data.pop_front());
                    end
                    beats++;
                end
            end
            if (wr3 && !wrote && busy[u] && !out_valid[u] && rd_addr[u] == 5'd3) begin
                we    = 1'b1;
                waddr = 5'd3;
                wdata = wr3_val;
                wrote = 1'b1;
            end
            prev_stall = out_valid[u] && !out_ready[u] && !abort[u];
            p_idx      = out_idx[u];
            p_data     = out_data[u];

            if (done_n >= 0 && n >= done_n + 2) break;
            if (n > 400) begin
                check("dump_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
            n++;
        end
        we = 1'b0; abort[u] = 1'b0; start[u] = 1'b0;

        check("beat_count", 32'(beats), 32'(exp_beats));
        check("done_pulses", 32'(ndone), 32'd1);
        check("end_busy", 32'(busy[u]), 32'd0);
        check("first_valid_lat", 32'(first_v >= 1 && first_v <= 2), 32'd1);
        if (abort_idx >= 0)
            check("abort_done_lat", 32'(done_n), 32'(abort_n + 1));
        else if (!rand_rdy)
            check("done_lat", 32'(done_n >= 2 * exp_beats && done_n <= 2 * exp_beats + 1), 32'd1);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; abort[u] = 1'b0; out_ready[u] = 1'b0;
        end
        we = 1'b0; waddr = '0; wdata = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2 check_reset_vals("reset");

        // Full default-range dump with x2 = 0x24
        fill(0);
        @(negedge clk);
        rstn = 1'b1;
        run_dump(0, 0, 31, 1'b0, -1, 1'b0, 1'b0, 32'd0);

        // Narrow range with random backpressure
        fill(1);
        for (int k = 0; k < 3; k++) run_dump(1, 5, 7, 1'b1, -1, 1'b0, 1'b0, 32'd0);

        // Random backpressure with start re-pulsed while busy
        run_dump(0, 0, 31, 1'b1, -1, 1'b1, 1'b0, 32'd0);

        // Abort during SEND of index 10 with ready high
        run_dump(0, 0, 31, 1'b0, 10, 1'b0, 1'b0, 32'd0);

        // abort in IDLE is a no-op; start+abort in IDLE starts a dump
        @(negedge clk); abort[0] = 1'b1;
        @(negedge clk); abort[0] = 1'b0;
        check("idle_abort_busy", 32'(busy[0]), 32'd0);
        check("idle_abort_done", 32'(done[0]), 32'd0);
        @(negedge clk); start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0; abort[0] = 1'b0;
        check("start_wins_busy", 32'(busy[0]), 32'd1);
        abort[0] = 1'b1;
        @(negedge clk); abort[0] = 1'b0;
        check("read_abort_busy", 32'(busy[0]), 32'd0);
        check("read_abort_done", 32'(done[0]), 32'd1);
        @(negedge clk);
        check("read_abort_done_once", 32'(done[0]), 32'd0);

        // Write to x3 on the READ edge of x3: old value now, new value next dump
        run_dump(0, 0, 31, 1'b0, -1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        run_dump(0, 0, 31, 1'b0, -1, 1'b0, 1'b0, 32'd0);
        check("x3_new_value_seen", regs[3], 32'hDEAD_BEEF);

        // Asynchronous reset mid-cycle during READ of index 4
        out_ready[0] = 1'b1;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        for (int k = 0; k < 50 && !(busy[0] && !out_valid[0] && rd_addr[0] == 5'd4); k++)
            @(negedge clk);
        check("reached_read4", 32'(busy[0] && !out_valid[0] && rd_addr[0] == 5'd4), 32'd1);
        #2 rstn = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done[0]), 32'd0);
        end

        // First start after reset release is honoured
        run_dump(0, 0, 31, 1'b0, -1, 1'b0, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
